// File: rtl/spell_ram_pkg.sv
// Shared types and constants for the spell shared-RAM responder.
package spell_ram_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned SEL_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_A = 2'd1,
      ST_GNT_B = 2'd2
   } state_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_t;

   // Write payload of whichever port holds the grant
   typedef struct packed {
      logic              we;
      logic [SEL_W-1:0]  sel;
      logic [WORD_W-1:0] dat;
   } wb_req_t;

endpackage

// File: rtl/spell_ram_rr_arb.sv
// Two-requester round-robin arbiter; grants only while the responder is idle.
module spell_ram_rr_arb
   import spell_ram_pkg::*;
(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_req_a,
   input  logic i_req_b,
   input  logic i_idle,
   output logic o_gnt_a_c,
   output logic o_gnt_b_c
);

   port_t r_last_grant;

   // On contention the port that was not served last wins
   always_comb begin
      o_gnt_a_c = 1'b0;
      o_gnt_b_c = 1'b0;
      if (i_idle) begin
         if (i_req_a && i_req_b) begin
            if (r_last_grant == PORT_B) o_gnt_a_c = 1'b1;
            else                        o_gnt_b_c = 1'b1;
         end else if (i_req_a) begin
            o_gnt_a_c = 1'b1;
         end else if (i_req_b) begin
            o_gnt_b_c = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset)        r_last_grant <= PORT_B;
      else if (o_gnt_a_c) r_last_grant <= PORT_A;
      else if (o_gnt_b_c) r_last_grant <= PORT_B;
   end

endmodule

// File: rtl/spell_ram_responder.sv
// Dual-port Wishbone classic responder for the spell shared RAM (spell core on
// port A, management firmware on port B) over one serialised storage port.
module spell_ram_responder
   import spell_ram_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                rambus_wb_cyc_i,
   input  logic                rambus_wb_stb_i,
   input  logic                rambus_wb_we_i,
   input  logic [SEL_W-1:0]    rambus_wb_sel_i,
   input  logic [9:0]          rambus_wb_addr_i,
   input  logic [WORD_W-1:0]   rambus_wb_dat_i,
   output logic                rambus_wb_ack_o,
   output logic [WORD_W-1:0]   rambus_wb_dat_o,
   input  logic                i_wb_cyc,
   input  logic                i_wb_stb,
   input  logic                i_wb_we,
   input  logic [SEL_W-1:0]    i_wb_sel,
   input  logic [31:0]         i_wb_addr,
   input  logic [WORD_W-1:0]   i_wb_data,
   output logic                o_wb_ack,
   output logic [WORD_W-1:0]   o_wb_data
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_ack_a;
   logic                r_ack_b;
   logic [WORD_W-1:0]   r_dat_a;
   logic [WORD_W-1:0]   r_dat_b;
   logic [WORD_W-1:0]   r_mem [DEPTH];

   logic                w_req_a;
   logic                w_req_b;
   logic                w_idle;
   logic                w_gnt_a;
   logic                w_gnt_b;
   logic [AW-1:0]       w_idx_a;
   logic [AW-1:0]       w_idx_b;
   logic [AW-1:0]       w_idx;
   wb_req_t             w_req_sel;
   logic                w_wr_en;
   logic                w_rd_a;
   logic                w_rd_b;
   logic                w_unused;

   // A port is not re-sampled during its own ack cycle
   assign w_req_a = rambus_wb_cyc_i & rambus_wb_stb_i & ~r_ack_a;
   assign w_req_b = i_wb_cyc & i_wb_stb & ~r_ack_b;
   assign w_idle  = (r_state == ST_IDLE);
   assign w_idx_a = rambus_wb_addr_i[AW+1:2];
   assign w_idx_b = i_wb_addr[AW+1:2];
   assign w_unused = ^{i_wb_addr[31:AW+2], i_wb_addr[1:0], rambus_wb_addr_i[1:0]};

   spell_ram_rr_arb u_arb (
      .i_clk     (clock),
      .i_reset   (reset),
      .i_req_a   (w_req_a),
      .i_req_b   (w_req_b),
      .i_idle    (w_idle),
      .o_gnt_a_c (w_gnt_a),
      .o_gnt_b_c (w_gnt_b)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_a)      w_state_nxt = ST_GNT_A;
            else if (w_gnt_b) w_state_nxt = ST_GNT_B;
         end
         ST_GNT_A, ST_GNT_B: w_state_nxt = ST_IDLE;
         default:            w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_ack_a <= 1'b0;
         r_ack_b <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ack_a <= (w_state_nxt == ST_GNT_A);
         r_ack_b <= (w_state_nxt == ST_GNT_B);
      end
   end

   // Single storage port: steer the granted port's address and payload
   always_comb begin
      w_idx         = w_gnt_a ? w_idx_a : w_idx_b;
      w_req_sel.we  = w_gnt_a ? rambus_wb_we_i  : i_wb_we;
      w_req_sel.sel = w_gnt_a ? rambus_wb_sel_i : i_wb_sel;
      w_req_sel.dat = w_gnt_a ? rambus_wb_dat_i : i_wb_data;
   end

   assign w_wr_en = ~reset & (w_gnt_a | w_gnt_b) & w_req_sel.we;
   assign w_rd_a  = ~reset & w_gnt_a & ~rambus_wb_we_i;
   assign w_rd_b  = ~reset & w_gnt_b & ~i_wb_we;

   // Storage is deliberately left without reset so it can map onto an SRAM macro
   always_ff @(posedge clock) begin
      if (w_wr_en) begin
         for (int k = 0; k < int'(SEL_W); k++) begin
            if (w_req_sel.sel[k]) r_mem[w_idx][8*k +: 8] <= w_req_sel.dat[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_dat_a <= '0;
         r_dat_b <= '0;
      end else begin
         if (w_rd_a) r_dat_a <= r_mem[w_idx];
         if (w_rd_b) r_dat_b <= r_mem[w_idx];
      end
   end

   assign rambus_wb_ack_o = r_ack_a;
   assign rambus_wb_dat_o = r_dat_a;
   assign o_wb_ack        = r_ack_b;
   assign o_wb_data       = r_dat_b;

endmodule

// File: tb/tb_spell_ram_responder.sv
// Directed bench for spell_ram_responder: reference word model plus queues of
// expected grant order and read data, compared as acks arrive.
module tb_spell_ram_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rambus_wb_cyc_i = 1'b0, rambus_wb_stb_i = 1'b0, rambus_wb_we_i = 1'b0;
   logic [3:0]  rambus_wb_sel_i = '0;
   logic [9:0]  rambus_wb_addr_i = '0;
   logic [31:0] rambus_wb_dat_i = '0;
   logic        rambus_wb_ack_o;
   logic [31:0] rambus_wb_dat_o;
   logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
   logic [3:0]  i_wb_sel = '0;
   logic [31:0] i_wb_addr = '0;
   logic [31:0] i_wb_data = '0;
   logic        o_wb_ack;
   logic [31:0] o_wb_data;

   spell_ram_responder dut (
      .clock            (clock),
      .reset            (reset),
      .rambus_wb_cyc_i  (rambus_wb_cyc_i),
      .rambus_wb_stb_i  (rambus_wb_stb_i),
      .rambus_wb_we_i   (rambus_wb_we_i),
      .rambus_wb_sel_i  (rambus_wb_sel_i),
      .rambus_wb_addr_i (rambus_wb_addr_i),
      .rambus_wb_dat_i  (rambus_wb_dat_i),
      .rambus_wb_ack_o  (rambus_wb_ack_o),
      .rambus_wb_dat_o  (rambus_wb_dat_o),
      .i_wb_cyc         (i_wb_cyc),
      .i_wb_stb         (i_wb_stb),
      .i_wb_we          (i_wb_we),
      .i_wb_sel         (i_wb_sel),
      .i_wb_addr        (i_wb_addr),
      .i_wb_data        (i_wb_data),
      .o_wb_ack         (o_wb_ack),
      .o_wb_data        (o_wb_data)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] mdl [256];
   bit          ord_q [$];
   logic [31:0] rd_q_a [$];
   logic [31:0] rd_q_b [$];
   logic [31:0] last_rd_a = '0;
   logic [31:0] last_rd_b = '0;
   int          ack_cyc_a, ack_cyc_b;
   int          acks_a [$];
   int          hold_a = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Queue one transfer on port A (pb=0) or B (pb=1); model updated in expected grant order
   task automatic req(input bit pb, input bit we, input logic [31:0] addr,
                      input logic [3:0] sel, input logic [31:0] dat);
      logic [7:0] idx;
      idx = addr[9:2];
      ord_q.push_back(pb);
      if (we) begin
         for (int k = 0; k < 4; k++)
            if (sel[k]) mdl[idx][8*k +: 8] = dat[8*k +: 8];
      end else if (pb) rd_q_b.push_back(mdl[idx]);
      else             rd_q_a.push_back(mdl[idx]);
      if (!pb) begin
         rambus_wb_cyc_i = 1'b1; rambus_wb_stb_i = 1'b1; rambus_wb_we_i = we;
         rambus_wb_sel_i = sel; rambus_wb_addr_i = 10'(addr); rambus_wb_dat_i = dat;
      end else begin
         i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
         i_wb_sel = sel; i_wb_addr = addr; i_wb_data = dat;
      end
   endtask

   task automatic consume(input bit pb);
      bit          eo;
      logic [31:0] e;
      if (ord_q.size() == 0) begin
         checks++; failures++;
         $error("FAIL spurious_ack port=%0d observed=ack expected=none", pb);
      end else begin
         eo = ord_q.pop_front();
         check("grant_order", 32'(pb), 32'(eo));
      end
      if (!pb) begin
         if (rambus_wb_we_i) check("a_dat_hold_on_write", rambus_wb_dat_o, last_rd_a);
         else if (rd_q_a.size() != 0) begin
            e = rd_q_a.pop_front();
            check("a_rdata", rambus_wb_dat_o, e);
            last_rd_a = e;
         end
      end else begin
         if (i_wb_we) check("b_dat_hold_on_write", o_wb_data, last_rd_b);
         else if (rd_q_b.size() != 0) begin
            e = rd_q_b.pop_front();
            check("b_rdata", o_wb_data, e);
            last_rd_b = e;
         end
      end
   endtask

   // Watch acks for a bounded number of cycles; each port drops its strobe on ack
   task automatic serve(input int want, input int budget);
      int got;
      got = 0; ack_cyc_a = -1; ack_cyc_b = -1;
      acks_a.delete();
      for (int c = 0; c < budget && got < want; c++) begin
         @(negedge clock);
         if (rambus_wb_ack_o) begin
            got++;
            if (ack_cyc_a < 0) ack_cyc_a = c;
            acks_a.push_back(c);
            consume(1'b0);
            if (hold_a > 0) hold_a--;
            else begin rambus_wb_cyc_i = 1'b0; rambus_wb_stb_i = 1'b0; end
         end
         if (o_wb_ack) begin
            got++;
            if (ack_cyc_b < 0) ack_cyc_b = c;
            consume(1'b1);
            i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
         end
      end
      check("ack_count", 32'(got), 32'(want));
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      last_rd_a = '0; last_rd_b = '0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_ack_a", 32'(rambus_wb_ack_o), 32'h0);
      check("rst_ack_b", 32'(o_wb_ack), 32'h0);
      check("rst_dat_a", rambus_wb_dat_o, 32'h0);
      check("rst_dat_b", o_wb_data, 32'h0);
      reset = 1'b0;

      // Port-A round trip
      @(posedge clock); #1 req(0, 1, 32'h004, 4'hF, 32'hDEADBEEF);
      serve(1, 10);
      check("a_wr_latency", 32'(ack_cyc_a), 32'd1);
      @(posedge clock); #1 req(0, 0, 32'h004, 4'hF, 32'h0);
      serve(1, 10);
      check("a_rd_latency", 32'(ack_cyc_a), 32'd1);

      // Byte lanes, including an empty select
      @(posedge clock); #1 req(0, 1, 32'h010, 4'hF, 32'h11223344); serve(1, 10);
      @(posedge clock); #1 req(0, 1, 32'h010, 4'h2, 32'h0000AA00); serve(1, 10);
      @(posedge clock); #1 req(0, 0, 32'h010, 4'hF, 32'h0);         serve(1, 10);
      @(posedge clock); #1 req(0, 1, 32'h010, 4'h0, 32'hFFFFFFFF); serve(1, 10);
      @(posedge clock); #1 req(0, 0, 32'h010, 4'hF, 32'h0);         serve(1, 10);

      // cyc low with stb high is not a request
      @(posedge clock); #1 rambus_wb_stb_i = 1'b1; rambus_wb_cyc_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         check("no_req_ack", 32'(rambus_wb_ack_o), 32'h0);
      end
      rambus_wb_stb_i = 1'b0;

      // Contention right after reset: A first, then B; then B first
      do_reset();
      @(posedge clock); #1;
      req(0, 1, 32'h020, 4'hF, 32'h1);
      req(1, 1, 32'h020, 4'hF, 32'h2);
      serve(2, 10);
      check("cont1_ack_a_cyc", 32'(ack_cyc_a), 32'd1);
      check("cont1_ack_b_cyc", 32'(ack_cyc_b), 32'd3);
      @(posedge clock); #1 req(0, 0, 32'h020, 4'hF, 32'h0); serve(1, 10);
      @(posedge clock); #1;
      req(1, 1, 32'h024, 4'hF, 32'h6);
      req(0, 1, 32'h024, 4'hF, 32'h5);
      serve(2, 10);
      check("cont2_ack_b_cyc", 32'(ack_cyc_b), 32'd1);
      check("cont2_ack_a_cyc", 32'(ack_cyc_a), 32'd3);
      @(posedge clock); #1 req(0, 0, 32'h024, 4'hF, 32'h0); serve(1, 10);

      // Reset asserted during the ack of a port-A read
      @(posedge clock); #1 req(0, 0, 32'h004, 4'hF, 32'h0);
      void'(ord_q.pop_front());
      @(negedge clock);
      @(negedge clock);
      check("abort_ack", 32'(rambus_wb_ack_o), 32'h1);
      if (rd_q_a.size() != 0) check("abort_rdata", rambus_wb_dat_o, rd_q_a.pop_front());
      reset = 1'b1; rambus_wb_cyc_i = 1'b0; rambus_wb_stb_i = 1'b0;
      @(negedge clock);
      check("rst_mid_ack", 32'(rambus_wb_ack_o), 32'h0);
      check("rst_mid_dat", rambus_wb_dat_o, 32'h0);
      reset = 1'b0; last_rd_a = '0; last_rd_b = '0;
      @(posedge clock); #1 req(0, 0, 32'h004, 4'hF, 32'h0); serve(1, 10);

      // Aliasing and sharing between ports
      @(posedge clock); #1 req(1, 1, 32'h3000_0404, 4'hF, 32'hCAFEF00D); serve(1, 10);
      @(posedge clock); #1 req(0, 0, 32'h004, 4'hF, 32'h0);        serve(1, 10);
      @(posedge clock); #1 req(0, 0, 32'h404, 4'hF, 32'h0);        serve(1, 10);
      @(posedge clock); #1 req(1, 0, 32'h3000_0004, 4'hF, 32'h0);  serve(1, 10);

      // Back-to-back reads with strobe held: acks on alternating cycles
      @(posedge clock); #1;
      req(0, 0, 32'h010, 4'hF, 32'h0);
      ord_q.push_back(1'b0); rd_q_a.push_back(mdl[8'h04]);
      ord_q.push_back(1'b0); rd_q_a.push_back(mdl[8'h04]);
      hold_a = 2;
      serve(3, 6);
      for (int k = 0; k < acks_a.size(); k++)
         check("b2b_ack_cyc", 32'(acks_a[k]), 32'(2*k + 1));

      repeat (2) @(negedge clock);
      check("final_idle_ack_a", 32'(rambus_wb_ack_o), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spell_ram_responder.md
Name: spell_ram_responder

Overview:
- Wishbone classic responder for the shared RAM: the far end of the `rambus_wb_*` initiator bus driven by the spell core.
- Holds DEPTH x 32-bit word storage with byte-lane writes.
- Exposes a second responder port to the management Wishbone (`i_wb_*`/`o_wb_*`), so the firmware can preload and inspect RAM.
- A two-way round-robin arbiter serialises the two ports. Sits in the user project wrapper next to spell.

Parameters:
- DEPTH, 256, number of 32-bit words.
- AW, 8, word-index width, = log2(DEPTH); word index = addr[AW+1:2].

Ports:
- clock  in  1  system clock; the top level ties `rambus_wb_clk_o` to the same net.
- reset  in  1  synchronous, active-high reset; ORed at top level with `rambus_wb_rst_o`.
- rambus_wb_cyc_i  in  1  port A cycle.
- rambus_wb_stb_i  in  1  port A strobe.
- rambus_wb_we_i  in  1  port A write enable.
- rambus_wb_sel_i  in  4  port A byte enables.
- rambus_wb_addr_i  in  10  port A byte address.
- rambus_wb_dat_i  in  32  port A write data.
- rambus_wb_ack_o  out  1  port A ack.
- rambus_wb_dat_o  out  32  port A read data.
- i_wb_cyc  in  1  port B cycle.
- i_wb_stb  in  1  port B strobe.
- i_wb_we  in  1  port B write enable.
- i_wb_sel  in  4  port B byte enables.
- i_wb_addr  in  32  port B byte address; only [AW+1:2] used, and the top level has already decoded the base.
- i_wb_data  in  32  port B write data.
- o_wb_ack  out  1  port B ack.
- o_wb_data  out  32  port B read data.

Behaviour:
- One clock and one synchronous active-high reset; no other clock domains.
- Request: `req_x = cyc & stb & ~ack_x`, so the port is not re-sampled during its own ack cycle.
- FSM states:
  - IDLE → GNT_A or GNT_B on the edge after a request is seen, if any request is pending.
  - GNT_x → IDLE after exactly one cycle.
- Arbitration in IDLE:
  - Single request: grant it.
  - Both requesting: grant the port that is not `last_grant`.
  - `last_grant` updates on every grant.
  - `last_grant` resets to B, so port A wins the first contention.
- Access, on the IDLE→GNT_x edge, using values sampled in that IDLE cycle:
  - Write: each byte lane k with sel[k]=1 is written from the data input; lanes with sel[k]=0 are unchanged. sel=0 writes nothing but is still acked.
  - Read: the addressed word is loaded into that port's dat_o register.
- Ack and read data:
  - ack_x is high exactly during GNT_x, i.e. one cycle after the request is first seen.
  - dat_o is valid during ack and holds until that port's next read.
  - A write never changes dat_o.
- Throughput:
  - One transfer per 2 cycles overall.
  - Master holds stb after its ack → new back-to-back transfer, considered in the next IDLE.
  - Under contention the ports alternate A,B,A,B.
- Address aliasing: byte address bits above AW+1 and bits [1:0] are ignored, so addresses wrap modulo DEPTH words.
- Port abort: cyc/stb dropped in the GNT cycle → ack still pulses for one cycle; a write already committed is not undone.
- cyc=0 with stb=1 is not a request.
- Reset values: both acks 0, both dat_o 0, FSM IDLE, `last_grant` B.
- Storage: not cleared by reset, in simulation or silicon; contents are undefined until written.
- Reset asserted in a GNT state → ack low on the next cycle; any write sampled before reset has already landed.
- Reads and writes are never simultaneous: a single storage port, with mutual exclusion guaranteed by the FSM.

Decomposition:
- Package `spell_ram_pkg`:
  - state encoding (IDLE=0, GNT_A=1, GNT_B=2);
  - grant encoding (PORT_A=0, PORT_B=1);
  - WORD_W=32, SEL_W=4.
- Sub-module `spell_ram_rr_arb`: two-requester round-robin arbiter holding `last_grant`, with inputs req_a, req_b, idle and one-hot grant outputs.
- Storage is an inferred register array in the top module, so it can later be swapped for a GF180 SRAM macro behind the same read/write strobes.

Test Plan:
1. Port-A round trip: reset; A writes 0xDEADBEEF to addr 0x004, sel=0xF → ack one cycle after stb. A reads 0x004 → rambus_wb_dat_o=0xDEADBEEF while ack=1.
2. Byte lanes: A writes 0x11223344 to addr 0x010, then sel=0x2 with data 0x0000AA00 → read returns 0x1122AA44.
3. Contention: after reset, A (write 0x1) and B (write 0x2) both request the same word in the same cycle.
   - Ack on A in cycle 1 and on B in cycle 3; the read returns 0x2.
   - The next simultaneous pair is served B first.
4. Aliasing and sharing: B writes 0xCAFEF00D to i_wb_addr=0x3000_0404 → A read at 0x004 returns 0xCAFEF00D. A read at 0x404 (wrap, DEPTH=256) also returns 0xCAFEF00D.
5. Reset mid-operation: assert reset during GNT_A of a read → rambus_wb_ack_o=0 and dat_o=0 next cycle. The word written in test 1 still reads 0xDEADBEEF afterwards.
6. Non-requests and back-to-back:
   - stb=1 with cyc=0 for 5 cycles → no ack.
   - A holds cyc/stb for 3 reads → acks on alternating cycles (3 acks in 6 cycles).
